seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: WIDTH RUN cycles from the start edge to done, start ignored until back in IDLE.
// Define SEQ_DIVIDER_ZERO_CHECK_EN to send B=0 straight to DONE with div_by_zero set.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    // The partial remainder's top bit is always zero before a shift, so only
    // the low WIDTH-1 bits are stored; the same holds for the quotient bits.
    logic [WIDTH-2:0] r_part;
    logic [WIDTH-2:0] r_quot;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_carry;
    logic [WIDTH-1:0] w_part_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    assign w_shift    = {r_part, r_dividend[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift} + {1'b0, ~r_divisor} + (WIDTH+1)'(1);
    assign w_carry    = w_diff[WIDTH];
    assign w_part_nxt = w_carry ? w_diff[WIDTH-1:0] : w_shift;
    assign w_quot_nxt = {r_quot, w_carry};

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    logic r_dbz;
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_part     <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_q_out    <= '0;
            r_r_out    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
            r_dbz      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dividend <= A;
                        r_divisor  <= B;
                        r_part     <= '0;
                        r_quot     <= '0;
                        r_cnt      <= '0;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                        if (B == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_q_out <= '1;
                            r_r_out <= A;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    r_part     <= w_part_nxt[WIDTH-2:0];
                    r_quot     <= w_quot_nxt[WIDTH-2:0];
                    r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_q_out <= w_quot_nxt;
                        r_r_out <= w_part_nxt;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
                        r_dbz   <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient  = r_q_out;
    assign Remainder = r_r_out;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule
